// File: rtl/tile_grid_renderer_pkg.sv
// Shared types and RGB332 colour constants for the tile grid overlay.
package tile_grid_pkg;

  typedef logic [10:0] pixel_t;

  localparam logic [7:0] LINE_COLOR_DEF = 8'hFF;
  localparam logic [7:0] BG_COLOR_DEF   = 8'h00;
  localparam logic [7:0] HL_COLOR_DEF   = 8'hFC;
  localparam logic [7:0] TRNS_COLOR_DEF = 8'hFF;
  localparam logic [7:0] CHECKER_ALT    = 8'h49;

  // Parity of (col + row) only depends on the two LSBs.
  function automatic logic tile_parity(input logic col_lsb, input logic row_lsb);
    return col_lsb ^ row_lsb;
  endfunction

  // Odd tiles take the fixed alternate colour, even tiles the background.
  function automatic logic [7:0] checker_color(input logic odd, input logic [7:0] bg);
    if (odd) begin
      return CHECKER_ALT;
    end else begin
      return bg;
    end
  endfunction

endpackage

// File: rtl/tile_grid_renderer_if.sv
// Pixel-in / colour-out bundle between the VGA timing path and the grid overlay.
interface tile_grid_renderer_if
  import tile_grid_pkg::*;
#(
  parameter int COLS = 40,
  parameter int ROWS = 30
) ();
  pixel_t                    pixel_x;
  pixel_t                    pixel_y;
  logic                      hl_en;
  logic [$clog2(COLS)-1:0]   hl_col;
  logic [$clog2(ROWS)-1:0]   hl_row;
  logic [7:0]                RGB_out;
  logic                      draw_request;
  logic [$clog2(COLS)-1:0]   tile_col;
  logic [$clog2(ROWS)-1:0]   tile_row;
  logic                      on_line;

  modport master (
    output pixel_x, pixel_y, hl_en, hl_col, hl_row,
    input  RGB_out, draw_request, tile_col, tile_row, on_line
  );

  modport slave (
    input  pixel_x, pixel_y, hl_en, hl_col, hl_row,
    output RGB_out, draw_request, tile_col, tile_row, on_line
  );
endinterface

// File: rtl/tile_grid_renderer_axis_tracker.sv
// One axis of the grid: sub-tile offset, tile index and sync flag, tracked
// incrementally from consecutive coordinates (no divide/modulo).
module grid_axis_tracker
  import tile_grid_pkg::*;
#(
  parameter int TILE   = 16,
  parameter int ORIGIN = 0,
  parameter int COUNT  = 40,
  parameter int LINE_W = 1
) (
  input  logic                       clk,
  input  logic                       resetN,
  input  pixel_t                     pos,
  output logic                       in_range,
  output logic                       on_line,
  output logic [$clog2(COUNT)-1:0]   idx
);
  localparam int SUB_W = $clog2(TILE);
  localparam int CNT_W = $clog2(COUNT + 2);
  localparam int IDX_W = $clog2(COUNT);

  localparam pixel_t             ORG      = pixel_t'(ORIGIN);
  localparam logic [SUB_W-1:0]   SUB_LAST = SUB_W'(TILE - 1);
  localparam logic [SUB_W-1:0]   SUB_LW   = SUB_W'(LINE_W);
  localparam logic [CNT_W-1:0]   CNT_END  = CNT_W'(COUNT);
  localparam logic [CNT_W-1:0]   CNT_MAX  = CNT_W'(COUNT + 1);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(COUNT - 1);

  pixel_t             prev_r;
  logic [SUB_W-1:0]   sub_r, sub_s;
  logic [CNT_W-1:0]   cnt_r, cnt_s;
  logic               sync_r, sync_s;

  // Next position: resync at the origin, hold on repeat, step on +1, lose sync otherwise.
  always_comb begin
    sub_s  = sub_r;
    cnt_s  = cnt_r;
    sync_s = sync_r;
    if (pos == ORG) begin
      sub_s  = {SUB_W{1'b0}};
      cnt_s  = {CNT_W{1'b0}};
      sync_s = 1'b1;
    end else if (pos == prev_r) begin
      sub_s  = sub_r;
      cnt_s  = cnt_r;
      sync_s = sync_r;
    end else if ((pos == prev_r + 11'd1) && sync_r) begin
      if (sub_r == SUB_LAST) begin
        sub_s = {SUB_W{1'b0}};
        // Counting past the closing border saturates one beyond it.
        if (cnt_r == CNT_MAX) begin
          cnt_s = cnt_r;
        end else begin
          cnt_s = cnt_r + 1'b1;
        end
      end else begin
        sub_s = sub_r + 1'b1;
        cnt_s = cnt_r;
      end
    end else begin
      sync_s = 1'b0;
    end
  end

  // Axis state register; it also holds the position of the pixel in stage 1.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      prev_r <= 11'd0;
      sub_r  <= {SUB_W{1'b0}};
      cnt_r  <= {CNT_W{1'b0}};
      sync_r <= 1'b0;
    end else begin
      prev_r <= pos;
      sub_r  <= sub_s;
      cnt_r  <= cnt_s;
      sync_r <= sync_s;
    end
  end

  // Region decode of the stage-1 pixel; the closing border reports the last tile.
  always_comb begin
    in_range = sync_r && ((cnt_r < CNT_END) || ((cnt_r == CNT_END) && (sub_r < SUB_LW)));
    on_line  = (sub_r < SUB_LW) || (cnt_r >= CNT_END);
    if (cnt_r >= CNT_END) begin
      idx = IDX_LAST;
    end else begin
      idx = cnt_r[IDX_W-1:0];
    end
  end
endmodule

// File: rtl/tile_grid_renderer.sv
// Tile grid overlay: two-stage pipeline (axis tracking/decode, then colour
// select) with a blinking highlighted tile. Optional macro GRID_CHECKER_EN
// alternates interior colours in a checkerboard.
module tile_grid_renderer
  import tile_grid_pkg::*;
#(
  parameter int         TILE_W     = 16,
  parameter int         TILE_H     = 16,
  parameter int         LINE_W     = 1,
  parameter int         COLS       = 40,
  parameter int         ROWS       = 30,
  parameter int         ORIGIN_X   = 0,
  parameter int         ORIGIN_Y   = 0,
  parameter logic [7:0] LINE_COLOR = LINE_COLOR_DEF,
  parameter logic [7:0] BG_COLOR   = BG_COLOR_DEF,
  parameter logic [7:0] HL_COLOR   = HL_COLOR_DEF,
  parameter logic [7:0] TRNS_COLOR = TRNS_COLOR_DEF,
  parameter int         BLINK_LOG2 = 5
) (
  input logic                  clk,
  input logic                  resetN,
  tile_grid_renderer_if.slave  bus
);
  localparam int COL_W = $clog2(COLS);
  localparam int ROW_W = $clog2(ROWS);

  logic               x_in_s, x_line_s, y_in_s, y_line_s;
  logic [COL_W-1:0]   col_s;
  logic [ROW_W-1:0]   row_s;
  logic               zero_r;
  logic [BLINK_LOG2:0] frame_r;
  logic               hl_en_r;
  logic [COL_W-1:0]   hl_col_r;
  logic [ROW_W-1:0]   hl_row_r;
  logic               in_area_s, line_s, hl_hit_s, dr_s;
  logic [7:0]         rgb_s;

  grid_axis_tracker #(.TILE(TILE_W), .ORIGIN(ORIGIN_X), .COUNT(COLS), .LINE_W(LINE_W)) u_x_axis (
    .clk(clk), .resetN(resetN), .pos(bus.pixel_x),
    .in_range(x_in_s), .on_line(x_line_s), .idx(col_s)
  );

  grid_axis_tracker #(.TILE(TILE_H), .ORIGIN(ORIGIN_Y), .COUNT(ROWS), .LINE_W(LINE_W)) u_y_axis (
    .clk(clk), .resetN(resetN), .pos(bus.pixel_y),
    .in_range(y_in_s), .on_line(y_line_s), .idx(row_s)
  );

  // Stage 1: frame counter on the rising edge of (0,0), and highlight sampling.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      zero_r   <= 1'b0;
      frame_r  <= '0;
      hl_en_r  <= 1'b0;
      hl_col_r <= '0;
      hl_row_r <= '0;
    end else begin
      if ((bus.pixel_x == 11'd0) && (bus.pixel_y == 11'd0)) begin
        zero_r <= 1'b1;
        if (!zero_r) begin
          frame_r <= frame_r + 1'b1;
        end else begin
          frame_r <= frame_r;
        end
      end else begin
        zero_r  <= 1'b0;
        frame_r <= frame_r;
      end
      hl_en_r  <= bus.hl_en;
      hl_col_r <= bus.hl_col;
      hl_row_r <= bus.hl_row;
    end
  end

  // Stage 2 colour priority: outside, line, blinking highlight, interior.
  always_comb begin
    in_area_s = x_in_s && y_in_s;
    line_s    = x_line_s || y_line_s;
    hl_hit_s  = hl_en_r && frame_r[BLINK_LOG2] &&
                (int'(hl_col_r) < COLS) && (int'(hl_row_r) < ROWS) &&
                (col_s == hl_col_r) && (row_s == hl_row_r);
    rgb_s     = TRNS_COLOR;
    dr_s      = 1'b0;
    if (!in_area_s) begin
      rgb_s = TRNS_COLOR;
      dr_s  = 1'b0;
    end else if (line_s) begin
      rgb_s = LINE_COLOR;
      dr_s  = 1'b1;
    end else if (hl_hit_s) begin
      rgb_s = HL_COLOR;
      dr_s  = 1'b1;
    end else begin
      dr_s  = 1'b1;
`ifdef GRID_CHECKER_EN
      rgb_s = checker_color(tile_parity(col_s[0], row_s[0]), BG_COLOR);
`else
      rgb_s = BG_COLOR;
`endif
    end
  end

  // Stage 2 output register.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      bus.RGB_out      <= TRNS_COLOR;
      bus.draw_request <= 1'b0;
      bus.tile_col     <= '0;
      bus.tile_row     <= '0;
      bus.on_line      <= 1'b0;
    end else begin
      bus.RGB_out      <= rgb_s;
      bus.draw_request <= dr_s;
      bus.tile_col     <= col_s;
      bus.tile_row     <= row_s;
      bus.on_line      <= in_area_s && line_s;
    end
  end
endmodule

// File: tb/tb_tile_grid_renderer.sv
// Scoreboard bench: three renderer instances (defaults, shifted origin,
// fast blink) share one raster stimulus; expected pixels are queued at issue
// and checked by a monitor two cycles later.
module tb_tile_grid_renderer;
  import tile_grid_pkg::*;

`ifdef GRID_CHECKER_EN
  localparam logic [7:0] ALT = 8'h49;
`else
  localparam logic [7:0] ALT = 8'h00;
`endif

  typedef struct {
    int         cyc;
    int         dut;
    string      name;
    logic [7:0] rgb;
    logic       dr;
    int         col;
    int         row;
    logic       ol;
    bit         full;
  } exp_t;

  logic clk;
  logic resetN;
  int   cyc;
  int   tests;
  int   failed;
  exp_t q[$];
  exp_t e;
  logic [7:0] a_rgb;
  logic       a_dr, a_ol;
  int         a_col, a_row;
  logic [7:0] hl_exp [1:5];

  tile_grid_renderer_if #(.COLS(40), .ROWS(30)) bus0 ();
  tile_grid_renderer_if #(.COLS(40), .ROWS(30)) bus1 ();
  tile_grid_renderer_if #(.COLS(40), .ROWS(30)) bus2 ();

  tile_grid_renderer dut0 (.clk(clk), .resetN(resetN), .bus(bus0));
  tile_grid_renderer #(.ORIGIN_X(32), .ORIGIN_Y(16)) dut1 (.clk(clk), .resetN(resetN), .bus(bus1));
  tile_grid_renderer #(.BLINK_LOG2(1)) dut2 (.clk(clk), .resetN(resetN), .bus(bus2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp_v);
    tests++;
    if (act !== exp_v) begin
      failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    end
  endtask

  task automatic px(input int x, input int y);
    @(posedge clk);
    #1;
    bus0.pixel_x = 11'(x); bus0.pixel_y = 11'(y);
    bus1.pixel_x = 11'(x); bus1.pixel_y = 11'(y);
    bus2.pixel_x = 11'(x); bus2.pixel_y = 11'(y);
  endtask

  task automatic ex(input int dut, input string name, input logic [7:0] rgb, input logic dr,
                    input int col, input int row, input logic ol, input bit full);
    exp_t n;
    n.cyc = cyc; n.dut = dut; n.name = name; n.rgb = rgb; n.dr = dr;
    n.col = col; n.row = row; n.ol = ol; n.full = full;
    q.push_back(n);
  endtask

  // Monitor: compares each queued expectation in the cycle its pixel emerges.
  always @(negedge clk) begin
    while (q.size() != 0 && q[0].cyc + 2 <= cyc) begin
      e = q.pop_front();
      if (e.cyc + 2 != cyc) begin
        tests++;
        failed++;
        $display("FAIL %s: output window missed at cycle %0d expected %0d", e.name, cyc, e.cyc + 2);
      end else begin
        case (e.dut)
          0: begin a_rgb = bus0.RGB_out; a_dr = bus0.draw_request; a_ol = bus0.on_line;
                   a_col = int'(bus0.tile_col); a_row = int'(bus0.tile_row); end
          1: begin a_rgb = bus1.RGB_out; a_dr = bus1.draw_request; a_ol = bus1.on_line;
                   a_col = int'(bus1.tile_col); a_row = int'(bus1.tile_row); end
          default: begin a_rgb = bus2.RGB_out; a_dr = bus2.draw_request; a_ol = bus2.on_line;
                   a_col = int'(bus2.tile_col); a_row = int'(bus2.tile_row); end
        endcase
        chk({e.name, ".rgb"}, int'(a_rgb), int'(e.rgb));
        chk({e.name, ".draw_request"}, int'(a_dr), int'(e.dr));
        if (e.full) begin
          chk({e.name, ".tile_col"}, a_col, e.col);
          chk({e.name, ".tile_row"}, a_row, e.row);
          chk({e.name, ".on_line"}, int'(a_ol), int'(e.ol));
        end
      end
    end
  end

  task automatic probe(input int f, input int x, input int y);
    if (f == 1) begin
      if (x == 0 && y == 0) begin
        ex(0, "d0_origin_line", 8'hFF, 1'b1, 0, 0, 1'b1, 1'b1);
        ex(1, "d1_before_origin", 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
      end
      if (x == 17 && y == 17) ex(0, "d0_tile_1_1", 8'h00, 1'b1, 1, 1, 1'b0, 1'b1);
      if (x == 16 && y == 17) ex(0, "d0_vline", 8'hFF, 1'b1, 1, 1, 1'b1, 1'b1);
      if (x == 33 && y == 17) ex(0, "d0_tile_2_1", ALT, 1'b1, 2, 1, 1'b0, 1'b1);
      if (x == 639 && y == 5) ex(0, "d0_last_interior", ALT, 1'b1, 39, 0, 1'b0, 1'b1);
      if (x == 640 && y == 5) ex(0, "d0_right_border", 8'hFF, 1'b1, 39, 0, 1'b1, 1'b1);
      if (x == 641 && y == 5) ex(0, "d0_past_border", 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
      if (x == 31 && y == 21) ex(1, "d1_left_of_origin", 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
      if (x == 32 && y == 16) ex(1, "d1_origin_line", 8'hFF, 1'b1, 0, 0, 1'b1, 1'b1);
      if (x == 49 && y == 33) ex(1, "d1_tile_1_1", 8'h00, 1'b1, 1, 1, 1'b0, 1'b1);
      if (x == 55 && y == 40) ex(0, "d0_hl_blink_off", ALT, 1'b1, 3, 2, 1'b0, 1'b1);
    end
    if (x == 55 && y == 40) ex(2, $sformatf("d2_hl_frame%0d", f), hl_exp[f], 1'b1, 3, 2, 1'b0, 1'b1);
    if (x == 48 && y == 40) ex(2, $sformatf("d2_hl_line_frame%0d", f), 8'hFF, 1'b1, 3, 2, 1'b1, 1'b1);
    if (f == 5 && x == 100 && y == 50) ex(0, "d0_tile_6_3", ALT, 1'b1, 6, 3, 1'b0, 1'b1);
  endtask

  task automatic jump_row();
    for (int x = 0; x <= 10; x++) begin
      px(x, 20);
      if (x == 5) ex(0, "jump_before", ALT, 1'b1, 0, 1, 1'b0, 1'b1);
    end
    for (int x = 200; x <= 205; x++) begin
      px(x, 20);
      if (x == 200) ex(0, "jump_lost", 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
      if (x == 205) ex(0, "jump_still_lost", 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
    end
    for (int x = 0; x <= 20; x++) begin
      px(x, 20);
      if (x == 0) ex(0, "resync_line", 8'hFF, 1'b1, 0, 1, 1'b1, 1'b1);
      if (x == 17) ex(0, "resync_interior", 8'h00, 1'b1, 1, 1, 1'b0, 1'b1);
    end
  endtask

  task automatic scan_frame(input int f, input int ymax);
    int xmax;
    for (int y = 0; y <= ymax; y++) begin
      if (f == 1 && y == 20) begin
        jump_row();
      end else begin
        xmax = (f == 1 && y == 5) ? 645 : ((f == 5 && y == 50) ? 100 : 60);
        for (int x = 0; x <= xmax; x++) begin
          px(x, y);
          probe(f, x, y);
        end
      end
    end
  endtask

  initial begin
    tests = 0; failed = 0; cyc = 0;
    hl_exp[1] = ALT; hl_exp[2] = 8'hFC; hl_exp[3] = 8'hFC; hl_exp[4] = ALT; hl_exp[5] = ALT;
    resetN = 1'b0;
    bus0.pixel_x = 11'd0; bus0.pixel_y = 11'd0; bus0.hl_en = 1'b1; bus0.hl_col = 6'd3; bus0.hl_row = 5'd2;
    bus1.pixel_x = 11'd0; bus1.pixel_y = 11'd0; bus1.hl_en = 1'b1; bus1.hl_col = 6'd3; bus1.hl_row = 5'd2;
    bus2.pixel_x = 11'd0; bus2.pixel_y = 11'd0; bus2.hl_en = 1'b1; bus2.hl_col = 6'd3; bus2.hl_row = 5'd2;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rgb", int'(bus0.RGB_out), 32'hFF);
    chk("reset_draw_request", int'(bus0.draw_request), 0);
    chk("reset_tile_col", int'(bus0.tile_col), 0);
    chk("reset_tile_row", int'(bus0.tile_row), 0);
    chk("reset_on_line", int'(bus0.on_line), 0);
    @(negedge clk);
    resetN = 1'b1;

    for (int f = 1; f <= 5; f++) begin
      scan_frame(f, (f == 5) ? 50 : 41);
    end
    px(100, 50);
    ex(0, "d0_hold", ALT, 1'b1, 6, 3, 1'b0, 1'b1);
    repeat (4) @(posedge clk);
    #2;
    resetN = 1'b0;
    #1;
    chk("midline_reset_rgb", int'(bus0.RGB_out), 32'hFF);
    chk("midline_reset_draw_request", int'(bus0.draw_request), 0);
    chk("midline_reset_tile_col", int'(bus0.tile_col), 0);
    chk("midline_reset_tile_row", int'(bus0.tile_row), 0);
    chk("midline_reset_on_line", int'(bus0.on_line), 0);
    @(negedge clk);
    resetN = 1'b1;
    px(101, 50);
    ex(0, "post_reset_unsynced", 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
    px(102, 50);
    ex(0, "post_reset_unsynced2", 8'hFF, 1'b0, 0, 0, 1'b0, 1'b0);
    px(0, 0);
    ex(0, "post_reset_resync", 8'hFF, 1'b1, 0, 0, 1'b1, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
